// File: rtl/ctrl_access_initiator.sv
// Control-path access initiator: turns host read/write commands into control
// packets on the ring and returns read data, or a timeout error, to the host.
module ctrl_access_initiator #(
    parameter int DATA_WIDTH     = 512,
    parameter int STREAM_ID_NUM  = 16,
    parameter int CHUNK_ID_NUM   = 32,
    parameter int CHANNEL_ID_NUM = 1024,
    parameter int STATE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SID_W          = $clog2(STREAM_ID_NUM),
    parameter int CHK_W          = $clog2(CHUNK_ID_NUM),
    parameter int CH_W           = $clog2(CHANNEL_ID_NUM)
) (
    input  logic                   clk,
    input  logic                   rstIn,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [CH_W-1:0]        cmd_hops,
    input  logic [SID_W-1:0]       cmd_streamID,
    input  logic [STATE_WIDTH-1:0] cmd_addr,
    input  logic [31:0]            cmd_wdata,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_error,

    output logic [DATA_WIDTH-1:0]  out_Data,
    output logic [1:0]             out_Type,
    output logic                   out_Last,
    output logic [SID_W-1:0]       out_StreamID,
    output logic [CHK_W-1:0]       out_ChunkID,
    output logic [CH_W-1:0]        out_ChannelID,
    output logic [STATE_WIDTH-1:0] out_State,

    input  logic [DATA_WIDTH-1:0]  in_Data,
    input  logic [1:0]             in_Type,
    input  logic                   in_Last,
    input  logic [SID_W-1:0]       in_StreamID,
    input  logic [CHK_W-1:0]       in_ChunkID,
    input  logic [CH_W-1:0]        in_ChannelID,
    input  logic [STATE_WIDTH-1:0] in_State
);

    localparam int REPS = DATA_WIDTH / 32;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CHK_W-2:0] OP_READ  = (CHK_W-1)'(0);
    localparam logic [CHK_W-2:0] OP_WRITE = (CHK_W-1)'(1);
    localparam logic [CHK_W-2:0] OP_RRSP  = (CHK_W-1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    state_t nextState;

    logic                   capWrite;
    logic [SID_W-1:0]       capStream;
    logic [STATE_WIDTH-1:0] capAddr;
    logic [TO_W-1:0]        toCnt;

    logic accept;
    logic match;
    logic timeout;

    assign cmd_ready = (state == IDLE) && !rstIn;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RESP);

    assign match = in_Type[1]
                && !in_ChunkID[CHK_W-1]
                && (in_ChunkID[CHK_W-2:0] == OP_RRSP)
                && (in_StreamID == capStream)
                && (in_State == capAddr);

    assign timeout = (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (accept) nextState = ISSUE;
            ISSUE: nextState = capWrite ? RESP : WAIT;
            WAIT:  if (match || timeout) nextState = RESP;
            RESP:  if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstIn) begin
            state     <= IDLE;
            out_Type  <= 2'b00;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            toCnt     <= '0;
        end else begin
            state    <= nextState;
            out_Type <= accept ? 2'b10 : 2'b00;
            if (state == ISSUE) begin
                toCnt <= '0;
                if (capWrite) begin
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                end
            end else if (state == WAIT) begin
                // a match on the final timeout cycle still delivers data
                if (match) begin
                    rsp_rdata <= in_Data[31:0];
                    rsp_error <= 1'b0;
                end else if (timeout) begin
                    rsp_rdata <= '0;
                    rsp_error <= 1'b1;
                end else begin
                    toCnt <= toCnt + TO_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            capWrite      <= cmd_write;
            capStream     <= cmd_streamID;
            capAddr       <= cmd_addr;
            out_Last      <= 1'b1;
            out_StreamID  <= cmd_streamID;
            out_ChannelID <= cmd_hops;
            out_State     <= cmd_addr;
            out_ChunkID   <= {1'b1, cmd_write ? OP_WRITE : OP_READ};
            out_Data      <= cmd_write ? {REPS{cmd_wdata}} : '0;
        end
    end

    logic unusedIn;
    assign unusedIn = ^{in_Data[DATA_WIDTH-1:32], in_Type[0], in_Last, in_ChannelID};

endmodule

// File: tb/tb_ctrl_access_initiator.sv
// Directed bench for ctrl_access_initiator with a 16-cycle read timeout.
module tb_ctrl_access_initiator;

    localparam int DW   = 512;
    localparam int SIDW = 4;
    localparam int CHKW = 5;
    localparam int CHW  = 10;
    localparam int SW   = 32;

    logic            clk = 1'b0;
    logic            rstIn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [CHW-1:0]  cmd_hops;
    logic [SIDW-1:0] cmd_streamID;
    logic [SW-1:0]   cmd_addr;
    logic [31:0]     cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_error;
    logic [31:0]     rsp_rdata;
    logic [DW-1:0]   out_Data, in_Data;
    logic [1:0]      out_Type, in_Type;
    logic            out_Last, in_Last;
    logic [SIDW-1:0] out_StreamID, in_StreamID;
    logic [CHKW-1:0] out_ChunkID, in_ChunkID;
    logic [CHW-1:0]  out_ChannelID, in_ChannelID;
    logic [SW-1:0]   out_State, in_State;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_access_initiator #(
        .DATA_WIDTH(DW), .STREAM_ID_NUM(16), .CHUNK_ID_NUM(32),
        .CHANNEL_ID_NUM(1024), .STATE_WIDTH(SW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstIn(rstIn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_hops(cmd_hops), .cmd_streamID(cmd_streamID),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .out_Data(out_Data), .out_Type(out_Type), .out_Last(out_Last),
        .out_StreamID(out_StreamID), .out_ChunkID(out_ChunkID),
        .out_ChannelID(out_ChannelID), .out_State(out_State),
        .in_Data(in_Data), .in_Type(in_Type), .in_Last(in_Last),
        .in_StreamID(in_StreamID), .in_ChunkID(in_ChunkID),
        .in_ChannelID(in_ChannelID), .in_State(in_State)
    );

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input int hops, input int sid,
                         input logic [31:0] addr, input logic [31:0] wd);
        check("cmdReadyPre", DW'(cmd_ready), DW'(1));
        cmd_write    = wr;
        cmd_hops     = CHW'(hops);
        cmd_streamID = SIDW'(sid);
        cmd_addr     = addr;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        step();
        cmd_valid    = 1'b0;
    endtask

    task automatic drivePkt(input logic [1:0] ty, input logic [4:0] chk,
                            input int sid, input logic [31:0] st,
                            input logic [31:0] d);
        in_Type     = ty;
        in_ChunkID  = chk;
        in_StreamID = SIDW'(sid);
        in_State    = st;
        in_Data     = {{(DW-32){1'b1}}, d};
        in_Last     = 1'b1;
    endtask

    task automatic finishRsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rspDrop", DW'(rsp_valid), DW'(0));
        check("readyBack", DW'(cmd_ready), DW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstIn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_hops = '0;
        cmd_streamID = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        in_Data = '0; in_Type = 2'b00; in_Last = 1'b0; in_StreamID = '0;
        in_ChunkID = '0; in_ChannelID = '0; in_State = '0;
        step();
        step();
        check("rstRdy", DW'(cmd_ready), DW'(0));
        check("rstVal", DW'(rsp_valid), DW'(0));
        check("rstType", DW'(out_Type), DW'(0));
        check("rstErr", DW'(rsp_error), DW'(0));
        check("rstData", DW'(rsp_rdata), DW'(0));
        rstIn = 1'b0;
        #1;
        check("postRstRdy", DW'(cmd_ready), DW'(1));

        // basic read
        issue(1'b0, 3, 2, 32'h40, 32'h0);
        check("rdType", DW'(out_Type), DW'(2'b10));
        check("rdChunk", DW'(out_ChunkID), DW'(5'b10000));
        check("rdChan", DW'(out_ChannelID), DW'(3));
        check("rdStream", DW'(out_StreamID), DW'(2));
        check("rdState", DW'(out_State), DW'(32'h40));
        check("rdLast", DW'(out_Last), DW'(1));
        check("rdData", out_Data, '0);
        check("rdBusy", DW'(cmd_ready), DW'(0));
        step();
        check("rdTypeOff", DW'(out_Type), DW'(0));
        step();
        drivePkt(2'b10, 5'b00001, 2, 32'h40, 32'hCAFEF00D);
        step();
        in_Type = 2'b00;
        check("rdVal", DW'(rsp_valid), DW'(1));
        check("rdRdata", DW'(rsp_rdata), DW'(32'hCAFEF00D));
        check("rdErr", DW'(rsp_error), DW'(0));
        finishRsp();

        // write
        issue(1'b1, 0, 0, 32'h8, 32'h12345678);
        check("wrType", DW'(out_Type), DW'(2'b10));
        check("wrData", out_Data, {16{32'h12345678}});
        check("wrChunk", DW'(out_ChunkID), DW'(5'b10001));
        check("wrChan", DW'(out_ChannelID), DW'(0));
        check("wrValEarly", DW'(rsp_valid), DW'(0));
        step();
        check("wrVal", DW'(rsp_valid), DW'(1));
        check("wrErr", DW'(rsp_error), DW'(0));
        check("wrRdata", DW'(rsp_rdata), DW'(0));
        check("wrTypeOff", DW'(out_Type), DW'(0));
        check("wrHoldData", out_Data, {16{32'h12345678}});
        finishRsp();

        // timeout, then a late response
        issue(1'b0, 1, 5, 32'h100, 32'h0);
        step();
        for (int i = 1; i < 16; i++) begin
            check("toWait", DW'(rsp_valid), DW'(0));
            step();
        end
        check("toWait16", DW'(rsp_valid), DW'(0));
        step();
        check("toVal", DW'(rsp_valid), DW'(1));
        check("toErr", DW'(rsp_error), DW'(1));
        check("toRdata", DW'(rsp_rdata), DW'(0));
        drivePkt(2'b10, 5'b00001, 5, 32'h100, 32'h11112222);
        step();
        in_Type = 2'b00;
        check("lateErr", DW'(rsp_error), DW'(1));
        check("lateRdata", DW'(rsp_rdata), DW'(0));
        finishRsp();

        // ignored packets before a real response
        issue(1'b0, 2, 7, 32'h200, 32'h0);
        step();
        drivePkt(2'b10, 5'b00001, 6, 32'h200, 32'hDEAD0001);
        step();
        check("misStream", DW'(rsp_valid), DW'(0));
        drivePkt(2'b10, 5'b00001, 7, 32'h204, 32'hDEAD0002);
        step();
        check("misAddr", DW'(rsp_valid), DW'(0));
        drivePkt(2'b01, 5'b00001, 7, 32'h200, 32'hDEAD0003);
        step();
        check("misType", DW'(rsp_valid), DW'(0));
        drivePkt(2'b10, 5'b10001, 7, 32'h200, 32'hDEAD0004);
        step();
        check("misRel", DW'(rsp_valid), DW'(0));
        drivePkt(2'b10, 5'b00001, 7, 32'h200, 32'hA5A50001);
        step();
        in_Type = 2'b00;
        check("misVal", DW'(rsp_valid), DW'(1));
        check("misRdata", DW'(rsp_rdata), DW'(32'hA5A50001));
        check("misErr", DW'(rsp_error), DW'(0));
        finishRsp();

        // response on the final WAIT cycle, host stalls
        issue(1'b0, 4, 3, 32'h300, 32'h0);
        step();
        for (int i = 1; i < 16; i++) step();
        check("lastNoVal", DW'(rsp_valid), DW'(0));
        drivePkt(2'b10, 5'b00001, 3, 32'h300, 32'h0BADBEEF);
        step();
        in_Type = 2'b00;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stallVal", DW'(rsp_valid), DW'(1));
            check("stallRdata", DW'(rsp_rdata), DW'(32'h0BADBEEF));
            check("stallErr", DW'(rsp_error), DW'(0));
            check("stallRdy", DW'(cmd_ready), DW'(0));
            check("stallType", DW'(out_Type), DW'(0));
            step();
        end
        cmd_valid = 1'b0;
        finishRsp();

        // reset while waiting
        issue(1'b0, 6, 9, 32'h400, 32'h0);
        step();
        step();
        rstIn = 1'b1;
        step();
        check("abortVal", DW'(rsp_valid), DW'(0));
        check("abortType", DW'(out_Type), DW'(0));
        rstIn = 1'b0;
        #1;
        check("abortRdy", DW'(cmd_ready), DW'(1));
        drivePkt(2'b10, 5'b00001, 9, 32'h400, 32'h99998888);
        step();
        in_Type = 2'b00;
        check("abortIgn", DW'(rsp_valid), DW'(0));
        step();
        check("abortIgn2", DW'(rsp_valid), DW'(0));
        issue(1'b0, 1, 1, 32'h10, 32'h0);
        check("reType", DW'(out_Type), DW'(2'b10));
        step();
        drivePkt(2'b10, 5'b00001, 1, 32'h10, 32'h5EED5EED);
        step();
        in_Type = 2'b00;
        check("reVal", DW'(rsp_valid), DW'(1));
        check("reRdata", DW'(rsp_rdata), DW'(32'h5EED5EED));
        check("reErr", DW'(rsp_error), DW'(0));
        finishRsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_access_initiator.md
CTRL_ACCESS_INITIATOR -- requirements
Module: ctrl_access_initiator

Interface
REQ-001 Parameters (name, default, meaning), one per line: DATA_WIDTH 512 packet data bus width, multiple of 32; STREAM_ID_NUM 16 virtual streams; CHUNK_ID_NUM 32 chunk IDs; CHANNEL_ID_NUM 1024 channel IDs; STATE_WIDTH 32 state/address width; TIMEOUT_CYCLES 1024 read-response timeout; derived SID_W/CHK_W/CH_W = $clog2 of the respective NUM.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rstIn  in  1  reset; synchronous, active-high.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  host command handshake.
REQ-005 cmd_write  in  1  1 = write, 0 = read.
REQ-006 cmd_hops  in  CH_W  target module distance; 0 = first module downstream.
REQ-007 cmd_streamID  in  SID_W; cmd_addr  in  STATE_WIDTH; cmd_wdata  in  32.
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  completion handshake.
REQ-009 rsp_rdata  out  32  read data; rsp_error  out  1  timeout flag.
REQ-010 out_Data, out_Type[1:0], out_Last, out_StreamID, out_ChunkID, out_ChannelID, out_State  out  (DATA_WIDTH, 2, 1, SID_W, CHK_W, CH_W, STATE_WIDTH)  request packet bus, registered.
REQ-011 in_Data, in_Type, in_Last, in_StreamID, in_ChunkID, in_ChannelID, in_State  in  same widths  return packet bus.

Function
REQ-012 Type encoding: bit1 = control packet valid, bit0 = data packet valid; ChunkID MSB 1 = relative, 0 = absolute; ChunkID[CHK_W-2:0] = opcode.
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP; cmd_ready = (state==IDLE) && !rstIn.
REQ-014 IDLE, cmd_valid&&cmd_ready at edge N -> state ISSUE; command fields captured; out bus loaded this same edge (visible cycle N+1).
REQ-015 Read packet: Type=2'b10, Last=1, ChunkID={1,opcode 0}, ChannelID=cmd_hops, StreamID=cmd_streamID, State=cmd_addr, Data=0.
REQ-016 Write packet: as read but opcode 1; Data = cmd_wdata replicated into all DATA_WIDTH/32 fields.
REQ-017 Every non-ISSUE cycle: out_Type=2'b00; other out fields hold last values.
REQ-018 ISSUE -> WAIT (read) or RESP (write) after exactly one cycle; write completes with rsp_rdata=0, rsp_error=0.
REQ-019 WAIT match: in_Type[1]=1 && in_ChunkID MSB=0 && opcode==1 (CTRL_READ_RESPONSE_32b) && in_StreamID==captured stream && in_State==captured addr.
REQ-020 Match -> RESP next edge; rsp_rdata=in_Data[31:0], rsp_error=0.
REQ-021 Timeout counter cleared on entering WAIT, +1 per unmatched WAIT cycle; the TIMEOUT_CYCLES-th unmatched cycle -> RESP with rsp_error=1, rsp_rdata=0.
REQ-022 Match and timeout in the same cycle: match wins (error=0).
REQ-023 Non-matching return packets and all packets outside WAIT (incl. late responses) ignored, no side effect.
REQ-024 RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_valid&&rsp_ready; then IDLE next edge; no new command accepted before that.
REQ-025 Minimum latency: accept edge N -> packet visible N+1 -> write rsp_valid N+2; read matched in cycle M -> rsp_valid M+1.

Reset
REQ-026 rstIn high at an edge: state=IDLE, out_Type=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, timeout counter=0; other out fields unspecified.
REQ-027 Reset in any state aborts the transaction with no response; cmd_ready=1 first cycle after rstIn falls.

Verification (TIMEOUT_CYCLES=16, CHK_W=5)
REQ-028 Read hops=3, stream=2, addr=0x40 -> one cycle Type=10, ChunkID=5'b10000, ChannelID=3, State=0x40; return ChunkID=5'b00001, stream 2, State 0x40, Data[31:0]=0xCAFEF00D two cycles later -> rsp_valid next cycle, rdata=0xCAFEF00D, error=0.
REQ-029 Write hops=0, addr=0x8, wdata=0x12345678 -> Data = 16 copies of 0x12345678, ChunkID=5'b10001; rsp_valid at N+2, error=0.
REQ-030 Read with no return -> rsp_valid exactly 16 cycles after WAIT entry, error=1, rdata=0; response injected one cycle later ignored.
REQ-031 WAIT with stream mismatch, then addr mismatch, then data packet (Type=01) -> ignored; correct response next -> completes, error=0.
REQ-032 Response arrives on 16th WAIT cycle -> error=0, data delivered; rsp_ready held low 5 cycles -> outputs stable, cmd_ready=0 until handshake.
REQ-033 rstIn asserted mid-WAIT -> rsp_valid never asserted, out_Type=0; new read after reset completes normally.
